// File: rtl/exp_engine_arbiter_pkg.sv
// Shared types and constants for the exp engine arbiter.
// FSM encoding, grant width, default timeout and FP32 reference values.
package exp_engine_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int GRANT_W     = 3;
    localparam int DEF_TIMEOUT = 64;

    localparam logic [31:0] FP32_ONE    = 32'h3F800000;
    localparam logic [31:0] FP32_EXP_M1 = 32'h3EBC5AB2;

    function automatic logic [GRANT_W-1:0] wrap_inc(
        input logic [GRANT_W-1:0] idx,
        input int                 n
    );
        return (int'(idx) == n - 1) ? '0 : idx + GRANT_W'(1);
    endfunction

endpackage

// File: rtl/exp_engine_arbiter_rr_priority_picker.sv
// Rotating-priority one-hot picker: first valid lane at or after ptr,
// wrapping modulo NUM_REQ.
module rr_priority_picker
    import exp_engine_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [GRANT_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GRANT_W-1:0] idx,
    output logic               any
);

    localparam int PW = GRANT_W + 1;

    logic [7:0]    valid_pad;
    logic [PW-1:0] pos;

    always_comb begin
        valid_pad = '0;
        valid_pad[NUM_REQ-1:0] = valid;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr} + PW'(i);
            if (pos >= PW'(NUM_REQ))
                pos = pos - PW'(NUM_REQ);
            if (!any && valid_pad[pos[GRANT_W-1:0]]) begin
                any = 1'b1;
                idx = pos[GRANT_W-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++)
            grant[k] = any && (idx == GRANT_W'(k));
    end

endmodule

// File: rtl/exp_engine_arbiter.sv
// Round-robin arbiter sharing one variable-latency exp engine between
// softmax lanes, one operation in flight, with a hung-engine timeout.
module exp_engine_arbiter
    import exp_engine_arbiter_pkg::*;
#(
    parameter int data_size      = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                           clock_i,
    input  logic                           reset_n_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*data_size-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [data_size-1:0]           rsp_data_o,
    output logic                           rsp_err_o,
    output logic                           eng_valid_o,
    output logic [data_size-1:0]           eng_data_o,
    input  logic                           eng_valid_i,
    input  logic [data_size-1:0]           eng_data_i,
    output logic                           busy_o,
    output logic [GRANT_W-1:0]             grant_id_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_e           state_q, state_d;
    logic [GRANT_W-1:0]   ptr_q;
    logic [GRANT_W-1:0]   grant_q;
    logic [data_size-1:0] op_q;
    logic [data_size-1:0] res_q;
    logic                 err_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 eng_valid_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 pick_any;
    logic [data_size-1:0] op_sel;

    logic                 accept;
    logic                 cnt_term;
    logic                 to_resp;
    logic                 eng_valid_d;
    logic [NUM_REQ-1:0]   rsp_valid_d;
    logic                 busy_d;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (req_valid_i),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        op_sel = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (pick_grant[k])
                op_sel = req_data_i[k*data_size +: data_size];
    end

    assign req_ready_o = (state_q == ST_IDLE) ? pick_grant : '0;

    // The counter holds the WAIT cycles already elapsed, so the terminal
    // cycle is the one that would bring it to TIMEOUT_CYCLES-1.
    assign cnt_term = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        to_resp     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (eng_valid_i || cnt_term) begin
                    to_resp = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        eng_valid_d = (state_d == ST_ISSUE);
        rsp_valid_d = (state_d == ST_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            op_q        <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            eng_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            eng_valid_q <= eng_valid_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            if (accept) begin
                op_q    <= op_sel;
                grant_q <= pick_idx;
                ptr_q   <= wrap_inc(pick_idx, NUM_REQ);
            end
            if (state_q == ST_ISSUE)
                cnt_q <= '0;
            else if (state_q == ST_WAIT)
                cnt_q <= cnt_q + CNT_W'(1);
            // A result on the terminal cycle beats the timeout.
            if (to_resp) begin
                res_q <= eng_valid_i ? eng_data_i : '0;
                err_q <= !eng_valid_i;
            end else if (state_q == ST_RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    assign eng_valid_o = eng_valid_q;
    assign eng_data_o  = op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = res_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = busy_q;
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Bench for exp_engine_arbiter: transaction-level reference model
// driven by directed scenarios and randomized traffic.
module tb_exp_engine_arbiter;
    import exp_engine_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 8;

    logic              clock_i = 1'b0;
    logic              reset_n_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     rsp_valid_o;
    logic [DW-1:0]     rsp_data_o;
    logic              rsp_err_o;
    logic              eng_valid_o;
    logic [DW-1:0]     eng_data_o;
    logic              eng_valid_i;
    logic [DW-1:0]     eng_data_i;
    logic              busy_o;
    logic [GRANT_W-1:0] grant_id_o;

    exp_engine_arbiter #(
        .data_size      (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .eng_valid_o (eng_valid_o),
        .eng_data_o  (eng_data_o),
        .eng_valid_i (eng_valid_i),
        .eng_data_i  (eng_data_i),
        .busy_o      (busy_o),
        .grant_id_o  (grant_id_o)
    );

    always #5 clock_i = ~clock_i;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          cyc;
    bit          txn;
    int          t_iss, t_eng, t_rsp;
    bit          eng_resp;
    int          tx_lane;
    logic [31:0] tx_op;
    int          ptr;
    bit          pend   [NR];
    logic [31:0] pdata  [NR];
    bit          sticky [NR];
    logic [31:0] sdata  [NR];
    int          lat_fix;
    bit          rnd_req;
    bit          stray_rnd;
    bit          force_stray;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h",
                     tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_model(input logic [31:0] x);
        if (x == 32'hBF800000) return FP32_EXP_M1;
        if (x == 32'h00000000) return FP32_ONE;
        return x ^ 32'h5A5A5A5A;
    endfunction

    function automatic int pick_lane();
        for (int i = 0; i < NR; i++)
            if (pend[(ptr + i) % NR]) return (ptr + i) % NR;
        return -1;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0: return 32'hBF800000;
            1: return 32'h00000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        logic [NR-1:0] er;
        int w, lat;
        @(posedge clock_i);
        #1;
        cyc++;
        if (txn && cyc > t_rsp) txn = 0;
        chk("eng_valid", 32'(eng_valid_o), 32'(txn && cyc == t_iss));
        chk("rsp_valid", 32'(rsp_valid_o),
            (txn && cyc == t_rsp) ? 32'(1 << tx_lane) : 32'd0);
        chk("busy", 32'(busy_o), 32'(txn && cyc >= t_iss && cyc <= t_rsp));
        if (txn && cyc == t_iss) begin
            chk("grant_id", 32'(grant_id_o), 32'(tx_lane));
            chk("eng_data", eng_data_o, tx_op);
        end
        if (txn && cyc == t_rsp) begin
            chk("rsp_err", 32'(rsp_err_o), 32'(!eng_resp));
            chk("rsp_data", rsp_data_o, eng_resp ? exp_model(tx_op) : 32'd0);
        end
        eng_valid_i = 1'b0;
        eng_data_i  = $urandom;
        if (txn && eng_resp && cyc == t_eng) begin
            eng_valid_i = 1'b1;
            eng_data_i  = exp_model(tx_op);
        end else if ((force_stray || (stray_rnd && $urandom_range(0, 7) == 0))
                     && (!txn || cyc == t_iss || cyc >= t_rsp)) begin
            eng_valid_i = 1'b1;
        end
        for (int l = 0; l < NR; l++) begin
            if (!pend[l]) begin
                if (sticky[l]) begin
                    pend[l]  = 1;
                    pdata[l] = sdata[l];
                end else if (rnd_req && $urandom_range(0, 3) == 0) begin
                    pend[l]  = 1;
                    pdata[l] = rand_op();
                end
            end else if (rnd_req && $urandom_range(0, 15) == 0) begin
                pend[l] = 0;
            end
            req_valid_i[l] = pend[l];
            req_data_i[l*DW +: DW] = pend[l] ? pdata[l] : $urandom;
        end
        #1;
        er = '0;
        w  = txn ? -1 : pick_lane();
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", 32'(req_ready_o), 32'(er));
        if (w >= 0) begin
            txn      = 1;
            tx_lane  = w;
            tx_op    = pdata[w];
            ptr      = (w + 1) % NR;
            pend[w]  = 0;
            lat      = (lat_fix >= 0) ? lat_fix : $urandom_range(1, TO + 1);
            t_iss    = cyc + 1;
            t_eng    = t_iss + lat;
            eng_resp = (lat <= TO - 1);
            t_rsp    = t_iss + 1 + (eng_resp ? lat : TO - 1);
        end
    endtask

    task automatic clear_reqs();
        for (int l = 0; l < NR; l++) begin
            pend[l]   = 0;
            sticky[l] = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data_o, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'd0);
        chk({tag, "_eng_valid"}, 32'(eng_valid_o), 32'd0);
        chk({tag, "_eng_data"}, eng_data_o, 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id_o), 32'd0);
    endtask

    initial begin
        cyc = 0; txn = 0; ptr = 0; t_iss = 0; t_eng = 0; t_rsp = 0;
        eng_resp = 0; tx_lane = 0; tx_op = '0;
        lat_fix = 3; rnd_req = 0; stray_rnd = 0; force_stray = 0;
        for (int l = 0; l < NR; l++) begin
            pend[l] = 0; sticky[l] = 0; pdata[l] = '0; sdata[l] = '0;
        end
        reset_n_i   = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        eng_valid_i = 1'b0;
        eng_data_i  = '0;
        repeat (2) @(posedge clock_i);
        #1;
        chk_all_zero("reset");
        @(negedge clock_i);
        reset_n_i = 1'b1;

        // single lane, L = 3
        pend[0] = 1; pdata[0] = 32'h00000000; lat_fix = 3;
        repeat (10) step();

        // both lanes continuously, L = 2
        sticky[0] = 1; sdata[0] = 32'hBF800000;
        sticky[1] = 1; sdata[1] = 32'h00000000;
        lat_fix = 2;
        repeat (24) step();
        clear_reqs();
        repeat (8) step();

        // engine never answers, then a normal request
        pend[0] = 1; pdata[0] = 32'h12345678; lat_fix = 100;
        repeat (14) step();
        pend[1] = 1; pdata[1] = 32'hBF800000; lat_fix = 2;
        repeat (8) step();

        // result on the terminal-count cycle
        pend[1] = 1; pdata[1] = 32'h00000000; lat_fix = TO - 1;
        repeat (14) step();

        // stray strobes in IDLE
        force_stray = 1;
        repeat (3) step();
        force_stray = 0;
        repeat (2) step();

        // reset during WAIT, then a late engine strobe
        pend[0] = 1; pdata[0] = 32'h3F800000; lat_fix = 6;
        repeat (3) step();
        #2;
        reset_n_i   = 1'b0;
        req_valid_i = '0;
        eng_valid_i = 1'b0;
        #1;
        chk_all_zero("async_rst");
        txn = 0; ptr = 0;
        clear_reqs();
        @(negedge clock_i);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        force_stray = 1;
        repeat (2) step();
        force_stray = 0;
        repeat (4) step();
        sticky[0] = 1; sdata[0] = 32'hBF800000;
        sticky[1] = 1; sdata[1] = 32'h00000000;
        lat_fix = 1;
        repeat (10) step();
        clear_reqs();
        repeat (8) step();

        // randomized traffic
        rnd_req = 1; stray_rnd = 1; lat_fix = -1;
        repeat (3000) step();
        rnd_req = 0; stray_rnd = 0;
        clear_reqs();
        repeat (TO + 6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exp_engine_arbiter.md
Name: exp_engine_arbiter

Overview:
Shares one exp datapath (FP32 in, FP32 out, variable latency, single-cycle valid pulse out) between NUM_REQ softmax lanes.
- Grants lanes round-robin and issues one operand at a time; only one operation is outstanding in the engine.
- Routes each result back to the issuing lane.
- Guards against a hung engine with a timeout.
- Sits between the per-lane max-subtract stage and the shared exp engine.

Parameters:
data_size, 32, operand/result width (IEEE-754 single).
NUM_REQ, 2, number of requesting lanes (2..8).
TIMEOUT_CYCLES, 64, max cycles to wait for the engine result before aborting (>=4).

Ports:
clock_i  in  1  clock, rising edge.
reset_n_i  in  1  asynchronous active-low reset.
req_valid_i  in  NUM_REQ  per-lane operand valid; held until accepted.
req_data_i  in  NUM_REQ*data_size  per-lane operand; lane k at bits [k*data_size +: data_size].
req_ready_o  out  NUM_REQ  one-hot accept; transfer on valid&ready.
rsp_valid_o  out  NUM_REQ  one-hot, single-cycle result strobe to the issuing lane.
rsp_data_o  out  data_size  result; valid only with rsp_valid_o.
rsp_err_o  out  1  qualifies rsp_valid_o; 1 = timeout abort, rsp_data_o = 0.
eng_valid_o  out  1  single-cycle operand strobe to the engine.
eng_data_o  out  data_size  operand to the engine; held stable from strobe until result or abort.
eng_valid_i  in  1  engine result strobe.
eng_data_i  in  data_size  engine result.
busy_o  out  1  high in any state other than IDLE.
grant_id_o  out  3  index of the lane currently owning the engine.

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, all outputs 0, timeout counter 0.
- Reset asserted mid-operation aborts silently; no rsp is emitted afterwards. Any late eng_valid_i after reset is ignored (rule for stray strobes below).
- FSM states:
  - IDLE: req_ready_o = one-hot of the winner, combinational from req_valid_i and the rr pointer. Search order is ptr, ptr+1, ..., wrapping mod NUM_REQ. On a transfer: latch operand and grant_id, set rr ptr = winner+1 (mod NUM_REQ), go to ISSUE. No valid request: stay.
  - ISSUE: eng_valid_o = 1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT: count cycles.
    - eng_valid_i = 1: latch eng_data_i, go to RESP.
    - Counter reaches TIMEOUT_CYCLES-1 without eng_valid_i: go to RESP with err = 1.
    - eng_valid_i on the terminal-count cycle: result wins, err = 0.
  - RESP: rsp_valid_o[grant_id] = 1 for one cycle with data/err; go to IDLE.
- req_ready_o is 0 in every state except IDLE.
- Latency: accept at cycle T → eng_valid_o at T+1. Engine returns at T+1+L (L >= 1) → rsp_valid_o at T+2+L. Next accept at T+3+L at the earliest.
- eng_valid_i seen in IDLE, ISSUE or RESP is a stray strobe: ignored, no state change.
- Every outputs is registered except req_ready_o.
- Fairness: with all lanes continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0; no lane waits more than NUM_REQ-1 grants.
- A lane dropping req_valid_i before acceptance is legal; it is simply skipped.
- Data is passed through unmodified; no arithmetic on payload.

Decomposition:
- Shared package holds:
  - FSM state encodings: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Width of grant_id (3).
  - Default TIMEOUT_CYCLES.
  - FP32 constants for the bench: 1.0 = 32'h3F800000, e^-1 = 32'h3EBC5AB2.
- One natural sub-module: rr_priority_picker (NUM_REQ-wide rotating-priority one-hot picker from valid vector + pointer).

Test Plan:
- Single lane 0 requests 32'h00000000, engine model returns 32'h3F800000 after L=3 → eng_valid_o at T+1, rsp_valid_o=2'b01 at T+5, data 3F800000, err 0.
- Both lanes hold valid continuously (lane0 32'hBF800000, lane1 32'h00000000), engine L=2 → grants alternate 0,1,0,1; lane0 gets 3EBC5AB2 and lane1 gets 3F800000, each response routed only to its own lane.
- Engine never responds, TIMEOUT_CYCLES=8 → rsp_valid_o one-hot to the issuer 8 cycles after eng_valid_o, err 1, data 0. Next request is accepted normally.
- eng_valid_i on the exact terminal-count cycle → err 0, engine data returned. Separately, a stray eng_valid_i in IDLE → no rsp, busy_o stays 0.
- reset_n_i asserted during WAIT, then engine strobes after release → outputs 0 immediately on assert, no rsp emitted, rr pointer back to 0.
